// File: rtl/power_integrator_if.sv
// Beat-in / integrated-beat-out bundle for the power integrator.
// The producer side (power stage / bench) uses master; the integrator uses slave.
interface power_integrator_if #(
    parameter int IN_DATA_WIDTH = 53,
    parameter int ACC_WIDTH     = 64,
    parameter int INDEX_WIDTH   = 11,
    parameter int NUM_FRAMES    = 16
);
    localparam int FCNT_W = $clog2(NUM_FRAMES);

    logic                       start;
    logic                       valid;
    logic [4*IN_DATA_WIDTH-1:0] col_1;
    logic [4*IN_DATA_WIDTH-1:0] col_2;
    logic [INDEX_WIDTH-1:0]     index_col1;
    logic [INDEX_WIDTH-1:0]     index_col2;

    logic                       busy;
    logic                       out_valid;
    logic [4*ACC_WIDTH-1:0]     out_col1;
    logic [4*ACC_WIDTH-1:0]     out_col2;
    logic [INDEX_WIDTH-1:0]     out_index_col1;
    logic [INDEX_WIDTH-1:0]     out_index_col2;
    logic [FCNT_W-1:0]          frame_cnt;
    logic                       run_done;
    logic                       sat_flag;
    logic                       idx_err;

    modport master (
        output start, valid, col_1, col_2, index_col1, index_col2,
        input  busy, out_valid, out_col1, out_col2, out_index_col1, out_index_col2,
               frame_cnt, run_done, sat_flag, idx_err
    );

    modport slave (
        input  start, valid, col_1, col_2, index_col1, index_col2,
        output busy, out_valid, out_col1, out_col2, out_index_col1, out_index_col2,
               frame_cnt, run_done, sat_flag, idx_err
    );
endinterface

// File: rtl/power_integrator.sv
// Incoherent integrator: accumulates 4-lane x 2-column power per bin over NUM_FRAMES
// frames in two per-column RAM banks and emits the integrated bins during the last frame.
module power_integrator #(
    parameter int IN_DATA_WIDTH = 53,
    parameter int ACC_WIDTH     = 64,
    parameter int INDEX_WIDTH   = 11,
    parameter int FRAME_LEN     = 2048,
    parameter int NUM_FRAMES    = 16
) (
    input  logic              clk,
    input  logic              rst,
    power_integrator_if.slave bus
);
    localparam int ROW_W  = 4 * ACC_WIDTH;
    localparam int ADDR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FCNT_W = $clog2(NUM_FRAMES);
    localparam logic [INDEX_WIDTH:0]   FRAME_LEN_W  = (INDEX_WIDTH + 1)'(FRAME_LEN);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX     = INDEX_WIDTH'(FRAME_LEN - 1);
    localparam logic [FCNT_W-1:0]      LAST_ACC_CNT = FCNT_W'(NUM_FRAMES - 2);

    typedef enum logic [1:0] {IDLE, FIRST, ACCUM, LAST} state_t;

    state_t            state_reg;
    logic              busy_reg;
    logic [FCNT_W-1:0] frame_cnt_reg;
    logic              idx_err_reg;
    logic              sat_flag_reg;

    // Bank 0 serves column 1, bank 1 serves column 2.
    logic [1:0][INDEX_WIDTH-1:0]     in_idx;
    logic [1:0][4*IN_DATA_WIDTH-1:0] in_data;
    logic [1:0][ROW_W-1:0]           conv_all;
    logic [1:0][ROW_W-1:0]           sum_all;
    logic [1:0][3:0]                 sat_all;

    logic in_range, accept, frame_end, start_ok, sat_hit;

    // Stage registers: accepted beat plus the mode it was tagged with.
    logic                        s_valid_reg;
    logic                        s_accum_reg;
    logic                        s_last_reg;
    logic                        s_end_reg;
    logic [1:0][INDEX_WIDTH-1:0] s_idx_reg;
    logic [1:0][ROW_W-1:0]       s_in_reg;

    logic                   out_valid_reg;
    logic [ROW_W-1:0]       out_col1_reg;
    logic [ROW_W-1:0]       out_col2_reg;
    logic [INDEX_WIDTH-1:0] out_index_col1_reg;
    logic [INDEX_WIDTH-1:0] out_index_col2_reg;
    logic                   last_out_reg;
    logic                   run_done_reg;

    assign in_idx    = {bus.index_col2, bus.index_col1};
    assign in_data   = {bus.col_2, bus.col_1};
    assign in_range  = ({1'b0, in_idx[0]} < FRAME_LEN_W) && ({1'b0, in_idx[1]} < FRAME_LEN_W);
    assign accept    = bus.valid && busy_reg && in_range;
    assign frame_end = accept && (in_idx[0] == LAST_IDX);
    assign start_ok  = bus.start && !busy_reg;
    assign sat_hit   = s_valid_reg && (|sat_all);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            frame_cnt_reg <= '0;
            idx_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg     <= FIRST;
                        busy_reg      <= 1'b1;
                        frame_cnt_reg <= '0;
                        idx_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    if (bus.valid && !in_range) begin
                        idx_err_reg <= 1'b1;
                    end
                    if (frame_end) begin
                        frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        case (state_reg)
                            FIRST: state_reg <= (NUM_FRAMES == 2) ? LAST : ACCUM;
                            ACCUM: begin
                                if (frame_cnt_reg == LAST_ACC_CNT) begin
                                    state_reg <= LAST;
                                end
                            end
                            default: begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // A new run clears the flag even if a tail beat of the previous run saturates now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_reg <= 1'b0;
        end else if (start_ok) begin
            sat_flag_reg <= 1'b0;
        end else if (sat_hit) begin
            sat_flag_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_reg <= 1'b0;
            s_accum_reg <= 1'b0;
            s_last_reg  <= 1'b0;
            s_end_reg   <= 1'b0;
            s_idx_reg   <= '0;
            s_in_reg    <= '0;
        end else begin
            s_valid_reg <= accept;
            if (accept) begin
                s_accum_reg <= (state_reg != FIRST);
                s_last_reg  <= (state_reg == LAST);
                s_end_reg   <= (state_reg == LAST) && (in_idx[0] == LAST_IDX);
                s_idx_reg   <= in_idx;
                s_in_reg    <= conv_all;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [ROW_W-1:0] mem [FRAME_LEN];
            logic [ROW_W-1:0] rd_reg;
            logic [ROW_W-1:0] fwd_reg;
            logic             hit_reg;
            logic [ROW_W-1:0] base;

            // The write of the beat in the stage lands on the same edge as the next read,
            // so a back-to-back repeat of an index takes the fresh sum instead of RAM data.
            assign base = hit_reg ? fwd_reg : rd_reg;

            for (genvar li = 0; li < 4; li++) begin : g_lane
                logic [ACC_WIDTH:0] wide;
                assign conv_all[gi][li*ACC_WIDTH +: ACC_WIDTH] =
                    in_data[gi][(li+1)*IN_DATA_WIDTH-1] ? '0 :
                    ACC_WIDTH'(in_data[gi][li*IN_DATA_WIDTH +: IN_DATA_WIDTH-1]);
                assign wide = {1'b0, base[li*ACC_WIDTH +: ACC_WIDTH]}
                            + {1'b0, s_in_reg[gi][li*ACC_WIDTH +: ACC_WIDTH]};
                assign sat_all[gi][li] = s_accum_reg && wide[ACC_WIDTH];
                assign sum_all[gi][li*ACC_WIDTH +: ACC_WIDTH] =
                    !s_accum_reg      ? s_in_reg[gi][li*ACC_WIDTH +: ACC_WIDTH] :
                    wide[ACC_WIDTH]   ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    rd_reg <= mem[in_idx[gi][ADDR_W-1:0]];
                end
                if (s_valid_reg) begin
                    mem[s_idx_reg[gi][ADDR_W-1:0]] <= sum_all[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hit_reg <= 1'b0;
                    fwd_reg <= '0;
                end else if (accept) begin
                    hit_reg <= s_valid_reg && (s_idx_reg[gi] == in_idx[gi]);
                    fwd_reg <= sum_all[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg      <= 1'b0;
            out_col1_reg       <= '0;
            out_col2_reg       <= '0;
            out_index_col1_reg <= '0;
            out_index_col2_reg <= '0;
            last_out_reg       <= 1'b0;
            run_done_reg       <= 1'b0;
        end else begin
            out_valid_reg <= s_valid_reg && s_last_reg;
            last_out_reg  <= s_valid_reg && s_end_reg;
            run_done_reg  <= last_out_reg;
            if (s_valid_reg && s_last_reg) begin
                out_col1_reg       <= sum_all[0];
                out_col2_reg       <= sum_all[1];
                out_index_col1_reg <= s_idx_reg[0];
                out_index_col2_reg <= s_idx_reg[1];
            end
        end
    end

    assign bus.busy           = busy_reg;
    assign bus.out_valid      = out_valid_reg;
    assign bus.out_col1       = out_col1_reg;
    assign bus.out_col2       = out_col2_reg;
    assign bus.out_index_col1 = out_index_col1_reg;
    assign bus.out_index_col2 = out_index_col2_reg;
    assign bus.frame_cnt      = frame_cnt_reg;
    assign bus.run_done       = run_done_reg;
    assign bus.sat_flag       = sat_flag_reg;
    assign bus.idx_err        = idx_err_reg;
endmodule

// File: tb/tb_power_integrator.sv
// Directed bench for power_integrator (4 frames per run, 54-bit accumulators, 12-bit index).
// Expected values are hand-computed per scenario; every comparison goes through check().
module tb_power_integrator;
    localparam int IW = 53;
    localparam int AW = 54;
    localparam int XW = 12;
    localparam int FL = 2048;
    localparam int NF = 4;
    localparam logic [IW-1:0] MAXP = 53'h0F_FFFF_FFFF_FFFF;
    localparam logic [IW-1:0] NEG1 = 53'h1F_FFFF_FFFF_FFFF;
    localparam logic [AW-1:0] SATV = 54'h3F_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    logic [XW-1:0]   q_i1 [$];
    logic [XW-1:0]   q_i2 [$];
    logic [4*AW-1:0] q_c1 [$];
    logic [4*AW-1:0] q_c2 [$];

    power_integrator_if #(.IN_DATA_WIDTH(IW), .ACC_WIDTH(AW), .INDEX_WIDTH(XW),
                          .NUM_FRAMES(NF)) bus ();

    power_integrator #(.IN_DATA_WIDTH(IW), .ACC_WIDTH(AW), .INDEX_WIDTH(XW),
                       .FRAME_LEN(FL), .NUM_FRAMES(NF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            q_i1.push_back(bus.out_index_col1);
            q_i2.push_back(bus.out_index_col2);
            q_c1.push_back(bus.out_col1);
            q_c2.push_back(bus.out_col2);
            $display("out beat idx1=%0d idx2=%0d col1=%0h col2=%0h",
                     bus.out_index_col1, bus.out_index_col2, bus.out_col1, bus.out_col2);
        end
        if (bus.run_done) begin
            done_cnt++;
        end
    end

    function automatic logic [4*IW-1:0] lanes(input logic [IW-1:0] l0, input logic [IW-1:0] l1,
                                              input logic [IW-1:0] l2, input logic [IW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [4*IW-1:0] rep(input logic [IW-1:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [4*AW-1:0] erep(input logic [AW-1:0] v);
        return {v, v, v, v};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [XW-1:0] i1, input logic [XW-1:0] i2,
                        input logic [4*IW-1:0] c1, input logic [4*IW-1:0] c2);
        bus.valid      = 1'b1;
        bus.index_col1 = i1;
        bus.index_col2 = i2;
        bus.col_1      = c1;
        bus.col_2      = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.valid = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic clear_log();
        q_i1.delete();
        q_i2.delete();
        q_c1.delete();
        q_c2.delete();
        done_cnt = 0;
    endtask

    task automatic end_beat(input logic [IW-1:0] v);
        beat(12'd2047, 12'd2047, rep(v), rep(v));
    endtask

    initial begin
        logic [XW-1:0] e1;
        logic [XW-1:0] e2;

        bus.start      = 1'b0;
        bus.valid      = 1'b0;
        bus.col_1      = '0;
        bus.col_2      = '0;
        bus.index_col1 = '0;
        bus.index_col2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_busy",      256'(bus.busy), 256'(0));
        check("rst_out_valid", 256'(bus.out_valid), 256'(0));
        check("rst_out_cols",  256'({bus.out_col1, bus.out_col2}), 256'(0));
        check("rst_flags",     256'({bus.frame_cnt, bus.run_done, bus.sat_flag, bus.idx_err}), 256'(0));

        // Reset in the middle of the LAST frame while a result beat is on the output
        pulse_start();
        beat(12'd1, 12'd1, rep(53'd5), rep(53'd5));
        end_beat(53'd5);
        end_beat(53'd5);
        end_beat(53'd5);
        beat(12'd1, 12'd1, rep(53'd5), rep(53'd5));
        idle(1);
        check("pre_rst_out_valid", 256'(bus.out_valid), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",      256'(bus.busy), 256'(0));
        check("mid_rst_out_valid", 256'(bus.out_valid), 256'(0));
        check("mid_rst_out_col1",  256'(bus.out_col1), 256'(0));
        check("mid_rst_frame_cnt", 256'(bus.frame_cnt), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Uniform input 5 over 4 frames -> 20 per lane in LAST
        clear_log();
        pulse_start();
        for (int f = 0; f < NF; f++) begin
            beat(12'd0, 12'd100, rep(53'd5), rep(53'd5));
            beat(12'd1, 12'd101, rep(53'd5), rep(53'd5));
            beat(12'd2, 12'd102, rep(53'd5), rep(53'd5));
            end_beat(53'd5);
            if (f < NF - 1) begin
                check($sformatf("t2_frame_cnt%0d", f), 256'(bus.frame_cnt), 256'(f + 1));
            end
        end
        idle(6);
        check("t2_beats", 256'(q_i1.size()), 256'(4));
        for (int k = 0; k < 4; k++) begin
            e1 = (k == 3) ? 12'd2047 : XW'(k);
            e2 = (k == 3) ? 12'd2047 : XW'(100 + k);
            check($sformatf("t2_idx1_%0d", k), 256'(q_i1[k]), 256'(e1));
            check($sformatf("t2_idx2_%0d", k), 256'(q_i2[k]), 256'(e2));
            check($sformatf("t2_col1_%0d", k), 256'(q_c1[k]), 256'(erep(54'd20)));
            check($sformatf("t2_col2_%0d", k), 256'(q_c2[k]), 256'(erep(54'd20)));
        end
        check("t2_run_done", 256'(done_cnt), 256'(1));
        check("t2_busy_end", 256'(bus.busy), 256'(0));

        // Back-to-back repeats of bin 7 in ACCUM must all accumulate (10+3, 20+6)
        clear_log();
        pulse_start();
        beat(12'd7, 12'd7, rep(53'd10), rep(53'd20));
        end_beat(53'd0);
        beat(12'd7, 12'd7, rep(53'd1), rep(53'd2));
        beat(12'd7, 12'd7, rep(53'd1), rep(53'd2));
        beat(12'd7, 12'd7, rep(53'd1), rep(53'd2));
        end_beat(53'd0);
        end_beat(53'd0);
        beat(12'd7, 12'd7, rep(53'd0), rep(53'd0));
        end_beat(53'd0);
        idle(6);
        check("t3_beats", 256'(q_i1.size()), 256'(2));
        check("t3_idx1",  256'(q_i1[0]), 256'(12'd7));
        check("t3_col1",  256'(q_c1[0]), 256'(erep(54'd13)));
        check("t3_col2",  256'(q_c2[0]), 256'(erep(54'd26)));
        check("t3_end_col1", 256'(q_c1[1]), 256'(0));
        check("t3_run_done", 256'(done_cnt), 256'(1));

        // Five max-positive inputs exceed 2^54-1 -> saturate
        clear_log();
        pulse_start();
        beat(12'd5, 12'd5, rep(MAXP), rep(MAXP));
        end_beat(53'd0);
        check("t4_sat_first", 256'(bus.sat_flag), 256'(0));
        repeat (4) beat(12'd5, 12'd5, rep(MAXP), rep(MAXP));
        end_beat(53'd0);
        check("t4_sat_accum", 256'(bus.sat_flag), 256'(1));
        end_beat(53'd0);
        beat(12'd5, 12'd5, rep(53'd0), rep(53'd0));
        end_beat(53'd0);
        idle(6);
        check("t4_col1", 256'(q_c1[0]), 256'(erep(SATV)));
        check("t4_col2", 256'(q_c2[0]), 256'(erep(SATV)));
        check("t4_sat_end", 256'(bus.sat_flag), 256'(1));

        // Beats while idle are ignored and do not flag index errors
        clear_log();
        beat(12'd3, 12'd3, rep(53'd999), rep(53'd999));
        beat(12'd2048, 12'd0, rep(53'd999), rep(53'd999));
        end_beat(53'd999);
        idle(4);
        check("t6_idle_idx_err", 256'(bus.idx_err), 256'(0));
        check("t6_idle_no_out",  256'(q_i1.size()), 256'(0));
        check("t6_idle_busy",    256'(bus.busy), 256'(0));

        // Out-of-range indices dropped, start while busy ignored, negative lane read as 0
        pulse_start();
        check("t5_sat_cleared", 256'(bus.sat_flag), 256'(0));
        beat(12'd3, 12'd3, rep(53'd4), rep(53'd4));
        beat(12'd2048, 12'd3, rep(53'd100), rep(53'd100));
        beat(12'd3, 12'd2048, rep(53'd100), rep(53'd100));
        end_beat(53'd0);
        check("t5_idx_err", 256'(bus.idx_err), 256'(1));
        check("t5_frame_cnt", 256'(bus.frame_cnt), 256'(1));
        pulse_start();
        check("t6_busy_start_cnt",  256'(bus.frame_cnt), 256'(1));
        check("t6_busy_start_busy", 256'(bus.busy), 256'(1));
        beat(12'd3, 12'd3, rep(53'd4), rep(53'd4));
        end_beat(53'd0);
        end_beat(53'd0);
        beat(12'd3, 12'd3, rep(53'd0), lanes(NEG1, 53'd1, 53'd1, 53'd1));
        end_beat(53'd0);
        idle(6);
        check("t5_col1", 256'(q_c1[0]), 256'(erep(54'd8)));
        check("t6_neg_col2", 256'(q_c2[0]), 256'({54'd9, 54'd9, 54'd9, 54'd8}));
        check("t5_idx_err_end", 256'(bus.idx_err), 256'(1));
        check("t5_run_done", 256'(done_cnt), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
